// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RISC-X core.
//   trap_state_t : sequencer states for trap_ctrl (IDLE, DRAIN, REDIRECT).
//   EXC_*        : machine-mode exception cause codes driven into mcause.
package core_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE     = 2'd0,
    TRAP_DRAIN    = 2'd1,
    TRAP_REDIRECT = 2'd2
  } trap_state_t;

  localparam logic [4:0] EXC_INSN_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSN    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT      = 5'd3;
  localparam logic [4:0] EXC_LOAD_FAULT      = 5'd5;
  localparam logic [4:0] EXC_ECALL_M         = 5'd11;

endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret return sequencer.
//
// Accepts one event while IDLE (priority EX exception > ID exception > mret),
// pulses the CSR strobes and front-end flushes combinationally in the
// acceptance cycle, waits in DRAIN while MEM/WB is busy, then redirects fetch
// for one cycle to mtvec (trap) or mepc (mret).
//
// Optional feature: define TRAP_CTRL_CNT_EN to add a 32-bit wrapping counter
// of accepted exceptions on trap_cnt_o; otherwise trap_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   exc_id_i / exc_id_cause_i         exception request + cause from ID
//   exc_ex_i / exc_ex_cause_i         exception request + cause from EX
//   mret_id_i                         mret decoded in ID
//   pipe_busy_i                       MEM/WB access outstanding
//   mtvec_i, mepc_i                   redirect sources from the CSR file
//   save_pc_id_o, save_pc_ex_o        CSR strobes: capture ID/EX PC to mepc
//   exception_cause_o                 cause for mcause (acceptance cycle only)
//   mstatus_trap_o, mstatus_mret_o    CSR mstatus update strobes
//   flush_if_o, flush_id_o, flush_ex_o  stage flushes
//   pc_redirect_o, pc_target_o        one-cycle fetch redirect and target
//   busy_o                            sequencer not IDLE
//   trap_cnt_o                        accepted-exception count
module trap_ctrl
  import core_pkg::*;
#(
  parameter int CAUSE_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exc_id_i,
  input  logic [CAUSE_W-1:0] exc_id_cause_i,
  input  logic               exc_ex_i,
  input  logic [CAUSE_W-1:0] exc_ex_cause_i,
  input  logic               mret_id_i,
  input  logic               pipe_busy_i,
  input  logic [31:0]        mtvec_i,
  input  logic [31:0]        mepc_i,
  output logic               save_pc_id_o,
  output logic               save_pc_ex_o,
  output logic [CAUSE_W-1:0] exception_cause_o,
  output logic               mstatus_trap_o,
  output logic               mstatus_mret_o,
  output logic               flush_if_o,
  output logic               flush_id_o,
  output logic               flush_ex_o,
  output logic               pc_redirect_o,
  output logic [31:0]        pc_target_o,
  output logic               busy_o,
  output logic [31:0]        trap_cnt_o
);

  trap_state_t state_q;
  logic        is_mret_q;

  logic idle;
  logic take_ex;
  logic take_id;
  logic take_mret;
  logic accept;

  // Acceptance strobes are combinational from the inputs, so they are also
  // gated by reset to keep every output at 0 while reset is held.
  assign idle      = (state_q == TRAP_IDLE) && !rst_i;
  assign take_ex   = idle && exc_ex_i;
  assign take_id   = idle && !exc_ex_i && exc_id_i;
  assign take_mret = idle && !exc_ex_i && !exc_id_i && mret_id_i;
  assign accept    = take_ex || take_id || take_mret;

  // mtvec direct mode: the low two (mode) bits never reach the target.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned; a missing default infers a latch.
  always_comb begin
    save_pc_id_o      = 1'b0;
    save_pc_ex_o      = 1'b0;
    exception_cause_o = '0;
    mstatus_trap_o    = 1'b0;
    mstatus_mret_o    = 1'b0;
    flush_if_o        = 1'b0;
    flush_id_o        = 1'b0;
    flush_ex_o        = 1'b0;
    pc_redirect_o     = 1'b0;
    pc_target_o       = 32'h0;

    if (take_ex) begin
      save_pc_ex_o      = 1'b1;
      exception_cause_o = exc_ex_cause_i;
      mstatus_trap_o    = 1'b1;
      flush_if_o        = 1'b1;
      flush_id_o        = 1'b1;
      flush_ex_o        = 1'b1;
    end else if (take_id) begin
      save_pc_id_o      = 1'b1;
      exception_cause_o = exc_id_cause_i;
      mstatus_trap_o    = 1'b1;
      flush_if_o        = 1'b1;
      flush_id_o        = 1'b1;
    end else if (take_mret) begin
      mstatus_mret_o    = 1'b1;
      flush_if_o        = 1'b1;
      flush_id_o        = 1'b1;
    end

    // Keep fetch flushed until the redirect lands.
    if (state_q == TRAP_DRAIN) begin
      flush_if_o = 1'b1;
    end

    if (state_q == TRAP_REDIRECT) begin
      flush_if_o    = 1'b1;
      pc_redirect_o = 1'b1;
      pc_target_o   = is_mret_q ? mepc_i : {mtvec_i[31:2], 2'b00};
    end
  end

  assign busy_o = (state_q != TRAP_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TRAP_IDLE;
      is_mret_q <= 1'b0;
    end else begin
      case (state_q)
        TRAP_IDLE: begin
          if (accept) begin
            is_mret_q <= take_mret;
            state_q   <= pipe_busy_i ? TRAP_DRAIN : TRAP_REDIRECT;
          end
        end
        TRAP_DRAIN: begin
          if (!pipe_busy_i) begin
            state_q <= TRAP_REDIRECT;
          end
        end
        TRAP_REDIRECT: begin
          state_q <= TRAP_IDLE;
        end
        default: begin
          state_q <= TRAP_IDLE;
        end
      endcase
    end
  end

`ifdef TRAP_CTRL_CNT_EN
  logic [31:0] trap_cnt_q;

  // Counts exceptions only; mret is not a trap. Wraps naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_cnt_q <= 32'h0;
    end else if (take_ex || take_id) begin
      trap_cnt_q <= trap_cnt_q + 32'd1;
    end
  end

  assign trap_cnt_o = trap_cnt_q;
`else
  assign trap_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl. Stimulus pushes the expected
// output snapshot of every strobe cycle (acceptance or redirect) into a queue;
// a monitor on the falling edge pops and compares whenever the DUT shows one.
module tb_trap_ctrl;
  import core_pkg::*;

  typedef struct packed {
    logic        sid;
    logic        sex;
    logic [4:0]  cause;
    logic        mtrap;
    logic        mmret;
    logic        fif;
    logic        fid;
    logic        fex;
    logic        redir;
    logic [31:0] tgt;
    logic        busy;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        exc_id_i = 1'b0;
  logic [4:0]  exc_id_cause_i = '0;
  logic        exc_ex_i = 1'b0;
  logic [4:0]  exc_ex_cause_i = '0;
  logic        mret_id_i = 1'b0;
  logic        pipe_busy_i = 1'b0;
  logic [31:0] mtvec_i = 32'h0000_0100;
  logic [31:0] mepc_i = 32'h0;
  logic        save_pc_id_o;
  logic        save_pc_ex_o;
  logic [4:0]  exception_cause_o;
  logic        mstatus_trap_o;
  logic        mstatus_mret_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        flush_ex_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        busy_o;
  logic [31:0] trap_cnt_o;

  int          total = 0;
  int          bad = 0;
  ev_t         exp_q[$];
  logic [31:0] exp_cnt = 32'h0;

  trap_ctrl #(.CAUSE_W(5)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .exc_id_i          (exc_id_i),
    .exc_id_cause_i    (exc_id_cause_i),
    .exc_ex_i          (exc_ex_i),
    .exc_ex_cause_i    (exc_ex_cause_i),
    .mret_id_i         (mret_id_i),
    .pipe_busy_i       (pipe_busy_i),
    .mtvec_i           (mtvec_i),
    .mepc_i            (mepc_i),
    .save_pc_id_o      (save_pc_id_o),
    .save_pc_ex_o      (save_pc_ex_o),
    .exception_cause_o (exception_cause_o),
    .mstatus_trap_o    (mstatus_trap_o),
    .mstatus_mret_o    (mstatus_mret_o),
    .flush_if_o        (flush_if_o),
    .flush_id_o        (flush_id_o),
    .flush_ex_o        (flush_ex_o),
    .pc_redirect_o     (pc_redirect_o),
    .pc_target_o       (pc_target_o),
    .busy_o            (busy_o),
    .trap_cnt_o        (trap_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t snap();
    ev_t s;
    s.sid   = save_pc_id_o;
    s.sex   = save_pc_ex_o;
    s.cause = exception_cause_o;
    s.mtrap = mstatus_trap_o;
    s.mmret = mstatus_mret_o;
    s.fif   = flush_if_o;
    s.fid   = flush_id_o;
    s.fex   = flush_ex_o;
    s.redir = pc_redirect_o;
    s.tgt   = pc_target_o;
    s.busy  = busy_o;
    return s;
  endfunction

  // Expected acceptance-cycle snapshot, priority EX > ID > mret.
  function automatic ev_t acc_ev(input bit ex, input bit id, input bit mr,
                                 input logic [4:0] cex, input logic [4:0] cid);
    ev_t e;
    e = '0;
    if (ex) begin
      e.sex = 1'b1; e.cause = cex; e.mtrap = 1'b1;
      e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1;
    end else if (id) begin
      e.sid = 1'b1; e.cause = cid; e.mtrap = 1'b1;
      e.fif = 1'b1; e.fid = 1'b1;
    end else if (mr) begin
      e.mmret = 1'b1; e.fif = 1'b1; e.fid = 1'b1;
    end
    return e;
  endfunction

  function automatic ev_t redir_ev(input logic [31:0] tgt);
    ev_t e;
    e = '0;
    e.fif = 1'b1; e.redir = 1'b1; e.tgt = tgt; e.busy = 1'b1;
    return e;
  endfunction

  // Monitor: any strobe cycle must match the head of the scoreboard.
  always @(negedge clk_i) begin
    ev_t cur;
    ev_t e;
    if (!rst_i) begin
      cur = snap();
      if (cur.sid || cur.sex || cur.mtrap || cur.mmret || cur.redir) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'(cur), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("event", 64'(cur), 64'(e));
        end
      end else begin
        check("idle_quiet", {27'h0, exception_cause_o, pc_target_o}, 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One request with d busy cycles; exp_tgt is the hand-computed target.
  // b2b holds an EX request (cause 3) through the REDIRECT cycle into IDLE.
  task automatic do_req(input bit ex, input bit id, input bit mr,
                        input logic [4:0] cex, input logic [4:0] cid,
                        input int d, input logic [31:0] exp_tgt, input bit b2b);
    step();
    exp_q.push_back(acc_ev(ex, id, mr, cex, cid));
    exp_q.push_back(redir_ev(exp_tgt));
    if (b2b) begin
      exp_q.push_back(acc_ev(1'b1, 1'b0, 1'b0, 5'd3, 5'd0));
      exp_q.push_back(redir_ev(exp_tgt));
    end
    if (ex || id) exp_cnt = exp_cnt + 32'd1;
    exc_ex_i = ex; exc_ex_cause_i = cex;
    exc_id_i = id; exc_id_cause_i = cid;
    mret_id_i = mr;
    for (int k = 0; k <= d; k++) begin
      pipe_busy_i = (k < d);
      if (k > 0) begin
        @(negedge clk_i);
        check("drain_state", {61'h0, busy_o, flush_if_o, pc_redirect_o}, 64'h6);
      end
      step();
      exc_ex_i = 1'b0; exc_id_i = 1'b0; mret_id_i = 1'b0;
    end
    // Now in the REDIRECT cycle.
    if (b2b) begin
      exc_ex_i = 1'b1; exc_ex_cause_i = 5'd3;
    end
    @(negedge clk_i);
    check("redirect_time", {63'h0, pc_redirect_o}, 64'h1);
    step();
    if (b2b) begin
      exp_cnt = exp_cnt + 32'd1;
      @(negedge clk_i);
      check("b2b_accept_idle", {63'h0, busy_o}, 64'h0);
      step();
      exc_ex_i = 1'b0;
      @(negedge clk_i);
      check("b2b_redirect", {63'h0, pc_redirect_o}, 64'h1);
      step();
    end
    @(negedge clk_i);
    check("idle_after", {63'h0, busy_o}, 64'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", 64'({snap(), trap_cnt_o}), 64'h0);
    step();
    rst_i = 1'b0;

    // EX trap, no drain
    mtvec_i = 32'h0000_0100;
    do_req(1'b1, 1'b0, 1'b0, EXC_ILLEGAL_INSN, 5'd0, 0, 32'h0000_0100, 1'b0);

    // Simultaneous EX and ID: only EX serviced
    mtvec_i = 32'h0000_0200;
    do_req(1'b1, 1'b1, 1'b0, EXC_LOAD_FAULT, EXC_ECALL_M, 0, 32'h0000_0200, 1'b0);

    // ID trap with 3-cycle drain, mode bits masked, back-to-back request
    mtvec_i = 32'h0000_0303;
    do_req(1'b0, 1'b1, 1'b0, 5'd0, EXC_ECALL_M, 3, 32'h0000_0300, 1'b1);

    // mret, no drain then with one drain cycle
    mepc_i = 32'h0000_2004;
    do_req(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 0, 32'h0000_2004, 1'b0);
    mepc_i = 32'h0000_3008;
    do_req(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1, 32'h0000_3008, 1'b0);

`ifdef TRAP_CTRL_CNT_EN
    check("cnt_after_mix", 64'(trap_cnt_o), 64'(exp_cnt));
`else
    check("cnt_tied_zero", 64'(trap_cnt_o), 64'h0);
`endif

    // Reset asserted in DRAIN aborts with no redirect
    step();
    exp_q.push_back(acc_ev(1'b0, 1'b1, 1'b0, 5'd0, EXC_ILLEGAL_INSN));
    exc_id_i = 1'b1; exc_id_cause_i = EXC_ILLEGAL_INSN; pipe_busy_i = 1'b1;
    step();
    exc_id_i = 1'b0;
    @(negedge clk_i);
    check("in_drain", {62'h0, busy_o, flush_if_o}, 64'h3);
    #2;
    rst_i = 1'b1;
    #1;
    check("reset_in_drain", 64'({snap(), trap_cnt_o}), 64'h0);
    step();
    step();
    rst_i = 1'b0;
    pipe_busy_i = 1'b0;
    exp_cnt = 32'h0;
    repeat (4) step();
    @(negedge clk_i);
    check("idle_after_abort", {63'h0, busy_o}, 64'h0);

    // Three traps plus one mret
    mtvec_i = 32'h0000_0400;
    mepc_i  = 32'h0000_1000;
    do_req(1'b1, 1'b0, 1'b0, EXC_INSN_MISALIGNED, 5'd0, 0, 32'h0000_0400, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 5'd0, EXC_BREAKPOINT, 0, 32'h0000_0400, 1'b0);
    do_req(1'b1, 1'b0, 1'b0, EXC_ECALL_M, 5'd0, 2, 32'h0000_0400, 1'b0);
    do_req(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 0, 32'h0000_1000, 1'b0);
`ifdef TRAP_CTRL_CNT_EN
    check("cnt_three", 64'(trap_cnt_o), 64'd3);
    // Wrap from all-ones
    force dut.trap_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.trap_cnt_q;
    check("cnt_forced", 64'(trap_cnt_o), 64'hFFFF_FFFF);
    do_req(1'b1, 1'b0, 1'b0, EXC_ILLEGAL_INSN, 5'd0, 0, 32'h0000_0400, 1'b0);
    check("cnt_wrap", 64'(trap_cnt_o), 64'h0);
`else
    check("cnt_still_zero", 64'(trap_cnt_o), 64'h0);
`endif

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
